seq_signed_multiplier: RTL and testbench
========================================

SEQ_SIGNED_MULTIPLIER -- requirements
Module: seq_signed_multiplier

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits (two's complement); WIDTH >= 2.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operand pair a/b valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept an operand pair.
REQ-006 SHALL have port: a  input  WIDTH  signed multiplicand.
REQ-007 SHALL have port: b  input  WIDTH  signed multiplier.
REQ-008 SHALL have port: out_valid  output  1  product valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts product.
REQ-010 SHALL have port: product  output  2*WIDTH  signed product a*b.
REQ-011 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 SHALL drive in_ready high only in IDLE; an accept occurs on a rising edge where in_valid and in_ready are both high.
REQ-014 On accept, SHALL register |a| and |b| as WIDTH-bit unsigned magnitudes (most-negative value maps to 2^(WIDTH-1)), register sign = a[MSB] xor b[MSB], clear the accumulator and bit counter, and enter CALC.
REQ-015 In CALC, SHALL process one multiplier magnitude bit per cycle, LSB first: add the multiplicand magnitude shifted left by the bit index to the 2*WIDTH-bit accumulator when that bit is 1.
REQ-016 SHALL stay in CALC exactly WIDTH cycles, then enter DONE with product = sign ? two's-complement negation of accumulator : accumulator.
REQ-017 Latency: accept at edge k -> out_valid high from the cycle after edge k+WIDTH.
REQ-018 In DONE, out_valid SHALL be high and product SHALL be held stable until out_ready is high on an edge; the FSM then returns to IDLE.
REQ-019 out_valid SHALL be low outside DONE; in_valid is ignored outside IDLE (no accept, no operand sampling).
REQ-020 Throughput: one product per WIDTH+2 cycles with out_ready held high; there is no bypass from DONE straight to CALC.
REQ-021 SHALL produce a zero product with sign forced positive (never a negative zero encoding issue): if the magnitude result is 0, product = 0.
REQ-022 Product width is 2*WIDTH; (-2^(WIDTH-1))*(-2^(WIDTH-1)) = 2^(2*WIDTH-2) fits without overflow.

Reset
REQ-023 When rst_n is low at a rising edge, SHALL enter IDLE, clear the accumulator, counter, sign and product, drive out_valid=0 and busy=0; in_ready=1 from the first cycle after reset release.
REQ-024 Reset asserted in CALC or DONE SHALL abort the operation and discard the result; no out_valid pulse follows.

Configuration
REQ-025 Macro MULT_EARLY_DONE_EN: when defined, an accept with |a|=0 or |b|=0 SHALL go from IDLE directly to DONE with product=0 (out_valid in the cycle after the accept edge); when undefined, every operation takes the full WIDTH CALC cycles.

Structure
REQ-026 Package conv_mult_pkg SHALL hold the FSM state enum typedef and the default operand width constant.
REQ-027 A sub-module operand_magnitude (WIDTH-bit signed in -> WIDTH-bit unsigned magnitude out, combinational) SHALL be instantiated twice, once per operand.

Verification
REQ-028 Reset, then a=3, b=5, out_ready=1 -> product=15, out_valid high exactly one cycle, 9 cycles after accept edge (WIDTH=8) plus return to IDLE.
REQ-029 a=-7, b=6 -> product=-42 (16'hFFD6); a=-128, b=-128 -> product=16384 (16'h4000); a=-128, b=127 -> -16256 (16'hC080).
REQ-030 a=12, b=-1 with out_ready low for 5 cycles -> product 16'hFFF4 held stable, out_valid high, in_ready low throughout; released on first out_ready edge.
REQ-031 rst_n low for one cycle mid-CALC (cycle 4) -> out_valid stays 0, busy=0, in_ready=1 next cycle; a new pair 2*2 then returns 4.
REQ-032 a=0, b=-93 -> product=0; with MULT_EARLY_DONE_EN out_valid one cycle after accept, without it after WIDTH+1 cycles.
REQ-033 Back-to-back stream of 1000 random pairs with random out_ready/in_valid stalls -> every product matches a*b in order, no drops or duplicates.

Source files
------------

// File: rtl/conv_mult_pkg.sv
// Shared types and defaults for the sequential signed multiplier.
// Holds the FSM state encoding and the default operand width.
package conv_mult_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/operand_magnitude.sv
// Two's-complement operand to unsigned magnitude; most-negative maps to 2^(WIDTH-1).
// Latency: combinational. Backpressure: none.
module operand_magnitude #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] mag
);

    assign mag = x[WIDTH-1] ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;

endmodule

// File: rtl/seq_signed_multiplier.sv
// Shift-add signed multiplier on magnitudes, one multiplier bit per cycle (IDLE/CALC/DONE).
// Latency: accept at edge k -> out_valid after edge k+WIDTH; zero operands shortcut when MULT_EARLY_DONE_EN is defined.
// Backpressure: product held in DONE until out_ready; in_ready only in IDLE, so no new accept while a result waits.
module seq_signed_multiplier
    import conv_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH);

    state_t               state, state_nx;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   prod_final;
    logic [CW-1:0]        cnt;
    logic                 sign;
    logic                 accept;
    logic                 last;

    operand_magnitude #(.WIDTH(WIDTH)) u_mag_a (.x(a), .mag(mag_a));
    operand_magnitude #(.WIDTH(WIDTH)) u_mag_b (.x(b), .mag(mag_b));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign last      = (cnt == CW'(WIDTH - 1));

    // mcand is pre-shifted each cycle so it always equals |a| << bit index
    assign acc_next   = acc + (mplier[0] ? mcand : '0);
    // A zero magnitude stays zero regardless of sign
    assign prod_final = (sign && (acc_next != '0)) ? -acc_next : acc_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef MULT_EARLY_DONE_EN
                    if ((mag_a == '0) || (mag_b == '0)) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = CALC;
                    end
`else
                    state_nx = CALC;
`endif
                end
            end
            CALC: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            sign    <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand   <= {{WIDTH{1'b0}}, mag_a};
                        mplier  <= mag_b;
                        acc     <= '0;
                        cnt     <= '0;
                        sign    <= a[WIDTH-1] ^ b[WIDTH-1];
                        product <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        product <= prod_final;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Self-checking bench for seq_signed_multiplier (WIDTH=8): directed cases, hold, mid-op reset, zero shortcut, random stream.
// Expected products come from plain signed multiplication in the bench.
module tb_seq_signed_multiplier;

    localparam int W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [W-1:0]      a = '0;
    logic [W-1:0]      b = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [2*W-1:0]    product;
    logic              busy;

    int checks = 0;
    int fails  = 0;

    seq_signed_multiplier #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input logic signed [W-1:0] x, input logic signed [W-1:0] y);
        logic signed [2*W-1:0] r;
        r = x * y;
        return r;
    endfunction

    task automatic start_op(input logic [W-1:0] xa, input logic [W-1:0] xb);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        a = xa;
        b = xb;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    // Number of edges after the accept edge until out_valid is visible; -1 on timeout
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (!out_valid) n = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || product !== '0) begin
            fails++;
            $display("FAIL reset_state: out_valid=%b busy=%b product=%h, want 0 0 0000", out_valid, busy, product);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        int n;
        out_ready = 1'b1;
        start_op(W'(3), W'(5));
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_busy: busy=%b in_ready=%b want 1 0", busy, in_ready);
        end
        wait_valid(n);
        checks++;
        if (n !== W) begin
            fails++;
            $display("FAIL basic_latency: got %0d edges want %0d", n, W);
        end
        checks++;
        if (product !== 16'd15) begin
            fails++;
            $display("FAIL basic_product: got %h want 000f", product);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_one_pulse: out_valid=%b in_ready=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_directed();
        int ta[6] = '{-7, -128, -128, 127, -1, 1};
        int tb_[6] = '{6, -128, 127, 127, -1, -128};
        logic [W-1:0] xa, xb;
        logic [2*W-1:0] exp_p;
        int n;
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i < 6) begin
                xa = W'(ta[i]);
                xb = W'(tb_[i]);
            end else begin
                xa = W'($urandom);
                xb = W'($urandom);
            end
            exp_p = ref_mul(xa, xb);
            start_op(xa, xb);
            wait_valid(n);
            checks++;
            if (n < 0 || product !== exp_p) begin
                fails++;
                $display("FAIL directed_%0d: %0d*%0d got %h (edges %0d) want %h", i,
                         $signed(xa), $signed(xb), product, n, exp_p);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_hold();
        int n;
        out_ready = 1'b0;
        start_op(W'(12), W'(-1));
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            // Offered operands while holding must be ignored
            in_valid = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            checks++;
            if (product !== 16'hFFF4 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL hold_%0d: product=%h out_valid=%b in_ready=%b want fff4 1 0", i, product, out_valid, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic seen;
        out_ready = 1'b1;
        start_op(W'(5), W'(7));
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL midreset_state: out_valid=%b busy=%b in_ready=%b want 0 0 1", out_valid, busy, in_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL midreset_no_valid: out_valid pulse seen=%b want 0", seen);
        end
        start_op(W'(2), W'(2));
        wait_valid(n);
        checks++;
        if (n < 0 || product !== 16'd4) begin
            fails++;
            $display("FAIL midreset_after: got %h (edges %0d) want 0004", product, n);
        end
        @(negedge clk);
    endtask

    task automatic test_zero();
        int n;
        int exp_n;
`ifdef MULT_EARLY_DONE_EN
        exp_n = 0;
`else
        exp_n = W;
`endif
        out_ready = 1'b1;
        start_op(W'(0), W'(-93));
        wait_valid(n);
        checks++;
        if (n !== exp_n || product !== '0) begin
            fails++;
            $display("FAIL zero_product: got %h after %0d edges want 0000 after %0d", product, n, exp_n);
        end
        @(negedge clk);
        start_op(W'(-128), W'(0));
        wait_valid(n);
        checks++;
        if (n !== exp_n || product !== '0) begin
            fails++;
            $display("FAIL zero_neg: got %h after %0d edges want 0000 after %0d", product, n, exp_n);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        localparam int N = 1000;
        logic [2*W-1:0] q[$];
        logic [2*W-1:0] exp_p;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int bad = 0;
        logic acc_pending = 1'b0;
        in_valid = 1'b0;
        while (got < N && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 1) == 1);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL stream_extra: product %h with nothing outstanding", product);
                end else begin
                    exp_p = q.pop_front();
                    if (product !== exp_p && bad < 10) begin
                        $display("FAIL stream_%0d: got %h want %h", got, product, exp_p);
                    end
                    if (product !== exp_p) bad++;
                end
                got++;
            end
            if (acc_pending) begin
                in_valid = 1'b0;
                acc_pending = 1'b0;
            end
            if (!in_valid && sent < N && $urandom_range(0, 9) < 7) begin
                in_valid = 1'b1;
                a = W'($urandom);
                b = W'($urandom);
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_mul(a, b));
                sent++;
                acc_pending = 1'b1;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL stream_values: %0d bad products want 0", bad);
        end
        checks++;
        if (got != N || sent != N || q.size() != 0) begin
            fails++;
            $display("FAIL stream_count: sent=%0d got=%0d left=%0d want %0d %0d 0", sent, got, q.size(), N, N);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_directed();
        test_hold();
        test_reset_mid();
        test_zero();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
